// File: rtl/ser_pkg.sv
// Shared definitions for the wide/narrow word (de)serializers: state encodings,
// a constant clog2 helper, and an elaboration-time width check.
`ifndef SER_PKG_SV
`define SER_PKG_SV

// Elaboration error unless IW is an integer multiple of OW with at least two beats.
`define SER_WIDTH_CHECK(IW, OW) \
  if ((((IW) % (OW)) != 0) || (((IW) / (OW)) < 2)) begin : g_width_check \
    $error("ser: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2"); \
  end

package ser_pkg;

  localparam logic [1:0] SER_EMPTY  = 2'b00;
  localparam logic [1:0] SER_ACTIVE = 2'b01;
  localparam logic [1:0] SER_FULL   = 2'b11;

  // Index width for 0..v-1; at least 1 bit so a 1-entry range still has a signal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

`endif

// File: rtl/beat_slice_mux.sv
// Selects beat idx_i of a wide word, in either most- or least-significant-first order.
module beat_slice_mux
  import ser_pkg::*;
#(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned Ratio    = IN_W / OUT_W,
  localparam int unsigned IdxW     = clog2(Ratio)
) (
  input  logic [IN_W-1:0]  word_i,
  input  logic [IdxW-1:0]  idx_i,
  output logic [OUT_W-1:0] slice_o
);

  logic [OUT_W-1:0] slices [Ratio];

  for (genvar i = 0; i < Ratio; i++) begin : g_slice
    if (MSB_FIRST) begin : g_msb
      assign slices[i] = word_i[IN_W-1-i*OUT_W -: OUT_W];
    end else begin : g_lsb
      assign slices[i] = word_i[i*OUT_W +: OUT_W];
    end
  end

  // Out-of-range indices (non power-of-two ratios) select zero.
  always_comb begin
    slice_o = '0;
    for (int i = 0; i < Ratio; i++) begin
      if (idx_i == IdxW'(i)) begin
        slice_o = slices[i];
      end
    end
  end

endmodule

// File: rtl/wide_to_narrow_serializer.sv
// Splits IN_W-bit words into IN_W/OUT_W beats over valid/ready, with a one-word
// pending buffer so consecutive words stream with no idle beat between them.
module wide_to_narrow_serializer
  import ser_pkg::*;
#(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned OUT_W     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             div_8_clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_first_o,
  output logic             out_last_o,
  output logic             busy_o
);

  `SER_WIDTH_CHECK(IN_W, OUT_W)

  localparam int unsigned Ratio = IN_W / OUT_W;
  localparam int unsigned BeatW = clog2(Ratio);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Ratio - 1);

  typedef enum logic [1:0] {
    StEmpty  = SER_EMPTY,
    StActive = SER_ACTIVE,
    StFull   = SER_FULL
  } state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   cur_q, cur_d;
  logic [IN_W-1:0]   pend_q, pend_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic              cur_valid, accept, beat_hs, last_hs;
  logic [OUT_W-1:0]  slice;

  assign cur_valid  = (state_q != StEmpty);
  // Depends only on registered state, so out_ready never reaches in_ready.
  assign in_ready_o = (state_q != StFull);
  assign accept     = in_valid_i & in_ready_o;
  assign beat_hs    = cur_valid & out_ready_i;
  assign last_hs    = beat_hs & (beat_q == LastBeat);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    beat_d  = beat_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          cur_d   = in_data_i;
          beat_d  = '0;
          state_d = StActive;
        end
      end
      StActive: begin
        if (last_hs) begin
          beat_d = '0;
          if (accept) begin
            cur_d = in_data_i;
          end else begin
            state_d = StEmpty;
          end
        end else begin
          if (beat_hs) begin
            beat_d = beat_q + 1'b1;
          end
          if (accept) begin
            pend_d  = in_data_i;
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (last_hs) begin
          cur_d   = pend_q;
          beat_d  = '0;
          state_d = StActive;
        end else if (beat_hs) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = StEmpty;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      cur_q   <= '0;
      pend_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      beat_q  <= beat_d;
    end
  end

  beat_slice_mux #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_slice_mux (
    .word_i  (cur_q),
    .idx_i   (beat_q),
    .slice_o (slice)
  );

  assign out_valid_o = cur_valid;
  assign out_data_o  = cur_valid ? slice : '0;
  assign out_first_o = cur_valid & (beat_q == '0);
  assign out_last_o  = cur_valid & (beat_q == LastBeat);
  assign busy_o      = cur_valid;

endmodule

// File: tb/tb_wide_to_narrow_serializer.sv
// Directed bench: vector table for the default 32->8 MSB-first instance, plus hand
// sequences for reset mid-word, LSB-first order and a 24->8 instance.
module tb_wide_to_narrow_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_first, out_last, busy;
  logic [7:0]  out_data;

  // LSB-first instance
  logic        l_in_valid = 1'b0;
  logic [31:0] l_in_data = '0;
  logic        l_in_ready, l_out_valid, l_out_first, l_out_last, l_busy;
  logic [7:0]  l_out_data;

  // 24-bit instance
  logic        t_in_valid = 1'b0;
  logic [23:0] t_in_data = '0;
  logic        t_in_ready, t_out_valid, t_out_first, t_out_last, t_busy;
  logic [7:0]  t_out_data;

  wide_to_narrow_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) dut (
    .div_8_clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_first_o(out_first), .out_last_o(out_last), .busy_o(busy)
  );

  wide_to_narrow_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .div_8_clk(clk), .rst_n(rst_n), .in_valid_i(l_in_valid), .in_ready_o(l_in_ready),
    .in_data_i(l_in_data), .out_valid_o(l_out_valid), .out_ready_i(1'b1),
    .out_data_o(l_out_data), .out_first_o(l_out_first), .out_last_o(l_out_last),
    .busy_o(l_busy)
  );

  wide_to_narrow_serializer #(.IN_W(24), .OUT_W(8), .MSB_FIRST(1'b1)) dut24 (
    .div_8_clk(clk), .rst_n(rst_n), .in_valid_i(t_in_valid), .in_ready_o(t_in_ready),
    .in_data_i(t_in_data), .out_valid_o(t_out_valid), .out_ready_i(1'b1),
    .out_data_o(t_out_data), .out_first_o(t_out_first), .out_last_o(t_out_last),
    .busy_o(t_busy)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic [12:0] exp; // {valid, data[7:0], first, last, in_ready, busy}
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic iv, input logic [31:0] d, input logic ordy,
                     input logic ev, input logic [7:0] ed, input logic ef,
                     input logic el, input logic eir, input logic eb);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.exp = {ev, ed, ef, el, eir, eb};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] obs();
    return {out_valid, out_data, out_first, out_last, in_ready, busy};
  endfunction

  logic [7:0] exp_b[4];

  initial begin
    // Single word
    add(1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 0, 1, 0);
    add(0, 0, 1, 1, 8'hA1, 1, 0, 1, 1);
    add(0, 0, 1, 1, 8'hB2, 0, 0, 1, 1);
    add(0, 0, 1, 1, 8'hC3, 0, 0, 1, 1);
    add(0, 0, 1, 1, 8'hD4, 0, 1, 1, 1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 1, 0);
    // Backpressure on B2
    add(1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 0, 1, 0);
    add(0, 0, 1, 1, 8'hA1, 1, 0, 1, 1);
    add(0, 0, 0, 1, 8'hB2, 0, 0, 1, 1);
    add(0, 0, 0, 1, 8'hB2, 0, 0, 1, 1);
    add(0, 0, 0, 1, 8'hB2, 0, 0, 1, 1);
    add(0, 0, 1, 1, 8'hB2, 0, 0, 1, 1);
    add(0, 0, 1, 1, 8'hC3, 0, 0, 1, 1);
    add(0, 0, 1, 1, 8'hD4, 0, 1, 1, 1);
    // Back-to-back words, third word stalled by in_ready
    add(1, 32'h11223344, 1, 0, 8'h00, 0, 0, 1, 0);
    add(1, 32'h55667788, 1, 1, 8'h11, 1, 0, 1, 1);
    add(1, 32'h99AABBCC, 1, 1, 8'h22, 0, 0, 0, 1);
    add(1, 32'h99AABBCC, 1, 1, 8'h33, 0, 0, 0, 1);
    add(1, 32'h99AABBCC, 1, 1, 8'h44, 0, 1, 0, 1);
    add(1, 32'h99AABBCC, 1, 1, 8'h55, 1, 0, 1, 1);
    add(0, 0, 1, 1, 8'h66, 0, 0, 0, 1);
    add(0, 0, 1, 1, 8'h77, 0, 0, 0, 1);
    add(0, 0, 1, 1, 8'h88, 0, 1, 0, 1);
    add(0, 0, 1, 1, 8'h99, 1, 0, 1, 1);
    add(0, 0, 1, 1, 8'hAA, 0, 0, 1, 1);
    add(0, 0, 1, 1, 8'hBB, 0, 0, 1, 1);
    // New word accepted on the last handshake with pend empty
    add(1, 32'hDEADBEEF, 1, 1, 8'hCC, 0, 1, 1, 1);
    add(0, 0, 1, 1, 8'hDE, 1, 0, 1, 1);
    add(0, 0, 1, 1, 8'hAD, 0, 0, 1, 1);
    add(0, 0, 1, 1, 8'hBE, 0, 0, 1, 1);
    add(0, 0, 1, 1, 8'hEF, 0, 1, 1, 1);
    add(0, 0, 1, 0, 8'h00, 0, 0, 1, 0);

    // Outputs while in reset
    #2;
    check("reset_outputs", 32'(obs()), 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    step();
    step();
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
      step();
    end
    in_valid = 1'b0;

    // Reset mid-word after beat B2 is presented
    in_valid = 1'b1; in_data = 32'hA1B2C3D4; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("pre_reset_b2", 32'(out_data), 32'h0000_00B2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 32'(obs()), 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_idle", 32'(obs()), 32'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    in_valid = 1'b1; in_data = 32'hCAFEBABE;
    step();
    in_valid = 1'b0;
    exp_b[0] = 8'hCA; exp_b[1] = 8'hFE; exp_b[2] = 8'hBA; exp_b[3] = 8'hBE;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cafe_beat%0d", i),
            32'({out_valid, out_data, out_first, out_last}),
            32'({1'b1, exp_b[i], i == 0, i == 3}));
      step();
    end
    check("cafe_done_busy", 32'({out_valid, busy}), 32'(2'b00));

    // LSB-first order
    l_in_valid = 1'b1; l_in_data = 32'hA1B2C3D4;
    step();
    l_in_valid = 1'b0;
    exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lsb_beat%0d", i),
            32'({l_out_valid, l_out_data, l_out_first, l_out_last}),
            32'({1'b1, exp_b[i], i == 0, i == 3}));
      step();
    end
    check("lsb_done", 32'({l_out_valid, l_busy, l_in_ready}), 32'(3'b001));

    // Three-beat 24->8 word
    t_in_valid = 1'b1; t_in_data = 24'h0A0B0C;
    step();
    t_in_valid = 1'b0;
    exp_b[0] = 8'h0A; exp_b[1] = 8'h0B; exp_b[2] = 8'h0C;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("w24_beat%0d", i),
            32'({t_out_valid, t_out_data, t_out_first, t_out_last}),
            32'({1'b1, exp_b[i], i == 0, i == 2}));
      step();
    end
    check("w24_done", 32'({t_out_valid, t_busy, t_in_ready}), 32'(3'b001));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
